fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_pkg.sv | 11 +
 rtl/fetch_ctrl_if.sv | 26 ++
 rtl/fetch_ctrl_skid.sv | 48 ++++
 rtl/fetch_ctrl.sv | 75 +++++++
 tb/tb_fetch_ctrl.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared widths and FSM state encoding for the fetch controller
package fetch_ctrl_pkg;
  localparam int PC_WIDTH = 32;
  localparam int IWIDTH = 32;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2,
    S_FLUSH = 2'd3
  } state_e;
endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: control, imem-return and decode-output signals of the fetch controller
//   master : fetch-stage top driving start/stall/branch and imem returns
//   slave  : fetch_ctrl driving PC control and the decode output register
interface fetch_ctrl_if;
  import fetch_ctrl_pkg::*;
  logic                fc_i_start;
  logic                fc_i_stall;
  logic                fc_i_branch;
  logic [PC_WIDTH-1:0] fc_i_target;
  logic [IWIDTH-1:0]   fc_i_instr;
  logic                fc_i_instr_ce;
  logic                fc_o_ce;
  logic                fc_o_change_pc;
  logic [PC_WIDTH-1:0] fc_o_pc;
  logic [IWIDTH-1:0]   fc_o_instr;
  logic                fc_o_valid;
  logic [1:0]          fc_o_state;
  modport master (
    output fc_i_start, fc_i_stall, fc_i_branch, fc_i_target, fc_i_instr, fc_i_instr_ce,
    input  fc_o_ce, fc_o_change_pc, fc_o_pc, fc_o_instr, fc_o_valid, fc_o_state
  );
  modport slave (
    input  fc_i_start, fc_i_stall, fc_i_branch, fc_i_target, fc_i_instr, fc_i_instr_ce,
    output fc_o_ce, fc_o_change_pc, fc_o_pc, fc_o_instr, fc_o_valid, fc_o_state
  );
endinterface

// File: rtl/fetch_ctrl_skid.sv
// fetch_skid: DEPTH-entry FIFO holding in-flight imem returns while decode is stalled
//   clk, rst   : clock, asynchronous active-high reset
//   clear      : drop all entries (redirect)
//   push, din  : enqueue an arrival
//   pop, dout  : dequeue the head (dout is the current head)
//   cnt        : number of valid entries
module fetch_skid #(
  parameter int DEPTH = 2,
  parameter int W = 32,
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] cnt
);
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else if (clear) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= inc(wr_q);
      if (pop) rd_q <= inc(rd_q);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push && !clear) mem_q[wr_q] <= din;
  assign dout = mem_q[rd_q];
  assign cnt = cnt_q;
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && !pop && !clear && cnt_q == CW'(DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && !clear && cnt_q == '0));
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage controller sequencing PC enables, redirects and the decode output register
//   fc_clk, fc_rst : clock, asynchronous active-high reset
//   bus (slave)    : start/stall/branch/imem return in; PC enable/load and registered decode output out
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int FETCH_LAT = 2
) (
  input logic fc_clk,
  input logic fc_rst,
  fetch_ctrl_if.slave bus
);
  localparam int CW = $clog2(FETCH_LAT + 1);
  state_e st_q, st_d;
  logic [CW-1:0] fl_q, fl_d, skid_cnt;
  logic [IWIDTH-1:0] instr_q, instr_d, skid_head;
  logic valid_q, valid_d, live, redirect, advance, push, pop;
  assign live = st_q == S_RUN || st_q == S_STALL;
  assign redirect = bus.fc_i_branch && st_q != S_IDLE;
  // decode moves on whenever it is not held, including the STALL cycle in which stall drops
  assign advance = live && !bus.fc_i_stall && !redirect;
  assign pop = advance && skid_cnt != '0;
  // arrivals bypass the buffer only when decode is free and nothing older is queued
  assign push = live && !redirect && bus.fc_i_instr_ce && (bus.fc_i_stall || skid_cnt != '0);
  fetch_skid #(.DEPTH(FETCH_LAT), .W(IWIDTH)) u_skid (
    .clk(fc_clk),
    .rst(fc_rst),
    .clear(redirect),
    .push(push),
    .pop(pop),
    .din(bus.fc_i_instr),
    .dout(skid_head),
    .cnt(skid_cnt)
  );
  always_ff @(posedge fc_clk or posedge fc_rst)
    if (fc_rst) begin
      st_q <= S_IDLE;
      fl_q <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      st_q <= st_d;
      fl_q <= fl_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  always_comb begin
    st_d = st_q;
    fl_d = fl_q;
    if (redirect) begin
      st_d = S_FLUSH;
      fl_d = CW'(FETCH_LAT);
    end else if (st_q == S_IDLE) st_d = bus.fc_i_start ? S_RUN : S_IDLE;
    else if (st_q != S_FLUSH) st_d = bus.fc_i_stall ? S_STALL : S_RUN;
    else begin
      fl_d = fl_q - 1'b1;
      if (fl_q == CW'(1)) st_d = bus.fc_i_stall ? S_STALL : S_RUN;
    end
  end
  always_comb begin
    instr_d = instr_q;
    valid_d = valid_q;
    if (!live || redirect) valid_d = 1'b0;
    else if (advance) begin
      valid_d = pop || bus.fc_i_instr_ce;
      instr_d = pop ? skid_head : bus.fc_i_instr_ce ? bus.fc_i_instr : instr_q;
    end
  end
  assign bus.fc_o_ce = redirect || (st_q == S_RUN && !bus.fc_i_stall && skid_cnt == '0);
  assign bus.fc_o_change_pc = redirect;
  assign bus.fc_o_pc = redirect ? bus.fc_i_target : '0;
  assign bus.fc_o_instr = instr_q;
  assign bus.fc_o_valid = valid_q;
  assign bus.fc_o_state = st_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scoreboard bench for fetch_ctrl with a PC + 2-cycle imem model
module tb_fetch_ctrl;
  logic clk, rst;
  int n_chk, n_err;
  logic [31:0] sb[$];
  logic [31:0] pc_m, a1;
  logic v1;
  fetch_ctrl_if bus();
  fetch_ctrl #(.FETCH_LAT(2)) dut (.fc_clk(clk), .fc_rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [31:0] m(input logic [31:0] a);
    return a == 32'd0 ? 32'h11 : a == 32'd4 ? 32'h22 : a == 32'd8 ? 32'h33 : 32'h1000_0000 | a;
  endfunction
  always @(posedge clk or posedge rst)
    if (rst) begin
      pc_m <= '0;
      a1 <= '0;
      v1 <= 1'b0;
      bus.fc_i_instr <= '0;
      bus.fc_i_instr_ce <= 1'b0;
    end else begin
      pc_m <= bus.fc_o_change_pc ? bus.fc_o_pc : bus.fc_o_ce ? pc_m + 32'd4 : pc_m;
      a1 <= pc_m;
      v1 <= bus.fc_o_ce;
      bus.fc_i_instr <= m(a1);
      bus.fc_i_instr_ce <= v1;
    end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst && bus.fc_o_valid && !bus.fc_i_stall) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL sb_extra: got %h expected nothing at %0t", bus.fc_o_instr, $time);
        end else chk("sb_instr", bus.fc_o_instr, sb.pop_front());
      end
    end
  endtask
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b0;
    bus.fc_i_start = 1'b0;
    bus.fc_i_stall = 1'b0;
    bus.fc_i_branch = 1'b0;
    bus.fc_i_target = '0;
    fork monitor(); join_none
    #1 rst = 1'b1;
    nxt();
    nxt();
    #2;
    chk("rst_state", 32'(bus.fc_o_state), 0);
    chk("rst_ce", 32'(bus.fc_o_ce), 0);
    chk("rst_change_pc", 32'(bus.fc_o_change_pc), 0);
    chk("rst_valid", 32'(bus.fc_o_valid), 0);
    chk("rst_instr", bus.fc_o_instr, 0);
    nxt();
    rst = 1'b0;
    bus.fc_i_start = 1'b1;
    foreach (sb[i]) sb.delete(i);
    for (int a = 0; a <= 36; a += 4) sb.push_back(m(32'(a)));
    #2 chk("ce_c0", 32'(bus.fc_o_ce), 0);
    nxt();
    #2;
    chk("ce_c1", 32'(bus.fc_o_ce), 1);
    chk("state_run", 32'(bus.fc_o_state), 1);
    repeat (7) nxt();
    bus.fc_i_stall = 1'b1;
    nxt();
    #2 chk("state_stall", 32'(bus.fc_o_state), 2);
    nxt();
    #2;
    chk("skid_cnt_full", 32'(dut.skid_cnt), 2);
    chk("instr_hold", bus.fc_o_instr, m(32'd16));
    nxt();
    bus.fc_i_stall = 1'b0;
    nxt();
    #2 chk("ce_drain", 32'(bus.fc_o_ce), 0);
    nxt();
    #2 chk("ce_resume", 32'(bus.fc_o_ce), 1);
    repeat (5) nxt();
    bus.fc_i_branch = 1'b1;
    bus.fc_i_target = 32'h40;
    #2;
    chk("br_change_pc", 32'(bus.fc_o_change_pc), 1);
    chk("br_pc", bus.fc_o_pc, 32'h40);
    chk("br_ce", 32'(bus.fc_o_ce), 1);
    nxt();
    bus.fc_i_branch = 1'b0;
    sb.push_back(m(32'h40));
    sb.push_back(m(32'h44));
    #2;
    chk("br_strobe_once", 32'(bus.fc_o_change_pc), 0);
    chk("state_flush", 32'(bus.fc_o_state), 3);
    repeat (7) nxt();
    bus.fc_i_branch = 1'b1;
    bus.fc_i_stall = 1'b1;
    bus.fc_i_target = 32'h80;
    nxt();
    bus.fc_i_branch = 1'b0;
    #2;
    chk("brst_flush", 32'(bus.fc_o_state), 3);
    chk("brst_skid_clr", 32'(dut.skid_cnt), 0);
    nxt();
    nxt();
    #2 chk("brst_stall", 32'(bus.fc_o_state), 2);
    nxt();
    nxt();
    bus.fc_i_stall = 1'b0;
    for (int a = 'h80; a <= 'h88; a += 4) sb.push_back(m(32'(a)));
    repeat (6) nxt();
    bus.fc_i_branch = 1'b1;
    bus.fc_i_target = 32'hC0;
    nxt();
    bus.fc_i_branch = 1'b0;
    #2 chk("pre_rst_flush", 32'(bus.fc_o_state), 3);
    rst = 1'b1;
    bus.fc_i_start = 1'b0;
    #1;
    chk("arst_state", 32'(bus.fc_o_state), 0);
    chk("arst_ce", 32'(bus.fc_o_ce), 0);
    chk("arst_change_pc", 32'(bus.fc_o_change_pc), 0);
    chk("arst_pc", bus.fc_o_pc, 0);
    chk("arst_valid", 32'(bus.fc_o_valid), 0);
    chk("arst_instr", bus.fc_o_instr, 0);
    nxt();
    nxt();
    rst = 1'b0;
    nxt();
    bus.fc_i_branch = 1'b1;
    bus.fc_i_target = 32'h10;
    #2;
    chk("idle_br_change_pc", 32'(bus.fc_o_change_pc), 0);
    chk("idle_br_ce", 32'(bus.fc_o_ce), 0);
    nxt();
    bus.fc_i_branch = 1'b0;
    #2;
    chk("idle_br_state", 32'(bus.fc_o_state), 0);
    chk("idle_valid", 32'(bus.fc_o_valid), 0);
    nxt();
    nxt();
    bus.fc_i_start = 1'b1;
    sb.push_back(32'h11);
    sb.push_back(32'h22);
    sb.push_back(32'h33);
    #2 chk("restart_ce_idle", 32'(bus.fc_o_ce), 0);
    nxt();
    #2 chk("restart_ce", 32'(bus.fc_o_ce), 1);
    repeat (6) nxt();
    bus.fc_i_stall = 1'b1;
    repeat (4) nxt();
    chk("sb_drained", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
